fetch_redirect_unit: RTL and testbench
======================================

// Module: fetch_redirect_unit
// PURPOSE
//  Fetch-side companion of the branch predictor: owns the PC register, picks next PC from the F-stage
//  prediction, and carries prediction metadata down the F->D->E registers.
//  In E, compares the prediction with the resolved outcome, raises mispredict/flush, and redirects the PC.
//  Drives the predictor's resolution port and keeps branch/mispredict performance counters.
// PARAMETERS
//  ADDRESS_WIDTH  32            PC/target width
//  DATA_WIDTH     32            instruction width
//  RESET_PC       32'h0000_0000 PC value loaded on reset
// PORTS
//  clk              in   1    clock, all state updates on posedge
//  reset            in   1    reset, synchronous, active-high
//  pcF              out  AW   current fetch PC (to imem and predictor)
//  branch_predictF  in   1    predictor: predicted taken for pcF
//  branch_targetF   in   AW   predictor: predicted next PC (target, or pcF+4)
//  instrF           in   DW   imem read data for pcF
//  stallF           in   1    hazard unit: hold pcF
//  stallD           in   1    hazard unit: hold D register
//  bubbleE          in   1    hazard unit: load bubble into E register
//  instrD           out  DW   decode-stage instruction
//  pcD              out  AW   decode-stage PC
//  pcE              out  AW   execute-stage PC (to predictor)
//  branchE          in   1    instr in E is a conditional branch/jump (from decode control)
//  takenE           in   1    resolved outcome in E
//  targetE_in       in   AW   resolved target in E
//  branch_valid     out  1    = validE & branchE (predictor update strobe)
//  branch_taken     out  1    = takenE, passthrough
//  targetE          out  AW   = targetE_in, passthrough
//  mispredictE      out  1    E-stage mispredict (combinational)
//  flushD, flushE   out  1    = mispredictE
//  perf_branches    out  32   resolved branch count
//  perf_mispredicts out  32   mispredict count
// BEHAVIOUR
//  Reset: pcF=RESET_PC; instrD=NOP (32'h0000_0013); pcD=0; pcE=0; validD=validE=0; predD/E=0;
//   predtgtD/E=0; perf counters=0; all comb outputs then evaluate with validE=0, so mispredictE=flush*=0.
//  E register: pcE, validE, predE, predtgtE.
//  Mispredict in E, only when validE=1:
//   branchE=1: mispredictE = (takenE!=predE) | (takenE & predE & targetE_in!=predtgtE).
//   branchE=0: mispredictE = predE (alias hit predicted taken on a non-branch).
//  Correct PC: takenE&branchE ? targetE_in : pcE+4; 32-bit add, wraps modulo 2^AW.
//  Next pcF, priority high->low: reset > mispredictE (correct PC) > stallF (hold) > branch_targetF.
//  F->D (posedge): mispredictE -> NOP, validD=0, predD=0 (beats stallD); else stallD -> hold;
//   else instrD=instrF, pcD=pcF, validD=1, predD=branch_predictF, predtgtD=branch_targetF.
//  D->E (posedge): mispredictE|bubbleE -> validE=0, predE=0, pcE=0; else copy D fields.
//  bubbleE with stallD: E gets the bubble and D holds.
//  Latency: prediction used in the same cycle as pcF; one-cycle redirect after an E mispredict,
//   with 2 wrong-path slots (D, E) flushed.
//  Perf counters (posedge): perf_branches += branch_valid; perf_mispredicts += mispredictE;
//   both free-running and wrap at 2^32.
//  Reset mid-operation wins over every other event; pipeline returns to the reset image next cycle.
// STRUCTURE
//  Package fetch_pkg: NOP_INSTR constant; typedef struct pred_meta_t {valid, pred, predtgt, pc}.
//  One sub-module fetch_pipe_reg (stage register with hold/flush, NOP-on-flush), instantiated for D and E.
//  PC mux, mispredict compare and perf counters stay in the top module.
// TESTING
//  1 Reset: reset=1 for 2 cycles, RESET_PC=0 -> pcF=0, instrD=0x13, all flags and counters 0.
//  2 Sequential: predictor returns not-taken (pcF+4) -> pcF 0,4,8,C; instrD trails instrF by 1 cycle.
//  3 Predicted-taken correct: pcF=0x10 pred T tgt 0x40; in E branchE=1, takenE=1, target 0x40
//    -> no flush, perf_branches=1, perf_mispredicts=0.
//  4 Direction mispredict: pred NT at 0x20, takenE=1 target 0x80 -> mispredictE=flushD=flushE=1,
//    pcF=0x80 next cycle, D and E hold bubbles, perf_mispredicts=1.
//  5 Alias/target mispredicts: non-branch at 0x30 with predE=1 -> pcF=0x34;
//    taken branch predtgt 0x100 vs target 0x200 -> pcF=0x200.
//  6 Conflicts: stallF=stallD=1 with mispredictE -> redirect wins, D flushed;
//    reset asserted during a mispredict -> pcF=RESET_PC; pcE=0xFFFFFFFC not-taken -> correct PC 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/redirect slice.
//  NOP_INSTR   : instruction loaded into the decode register on reset or flush
//  pred_meta_t : per-instruction prediction metadata carried from F through E
//  FETCH_AW    : address width of the metadata fields. The top-level
//                ADDRESS_WIDTH parameter must equal it.
package fetch_pkg;

  localparam int FETCH_AW = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                valid;    // slot holds a real instruction
    logic                pred;     // predictor said taken
    logic [FETCH_AW-1:0] predtgt;  // predicted next PC
    logic [FETCH_AW-1:0] pc;       // PC of the instruction
  } pred_meta_t;

endpackage

// File: rtl/fetch_pipe_reg.sv
// One pipeline stage register carrying an instruction word and its prediction metadata.
//  clk, reset : clock and synchronous active-high reset
//  flush      : load the empty image (NOP, all metadata zero); takes priority over hold
//  hold       : keep the current contents
//  instr_in   : instruction word presented by the previous stage
//  meta_in    : prediction metadata presented by the previous stage
//  instr_q    : registered instruction word
//  meta_q     : registered prediction metadata
// Reset and flush load the same image, so a flushed slot looks exactly like a
// slot that has just come out of reset.
module fetch_pipe_reg
  import fetch_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic [DW-1:0] instr_in,
  input  pred_meta_t    meta_in,
  output logic [DW-1:0] instr_q,
  output pred_meta_t    meta_q
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q <= DW'(NOP_INSTR);
      meta_q  <= '0;
    end else if (!hold) begin
      instr_q <= instr_in;
      meta_q  <= meta_in;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch-side companion of the branch predictor.
// Owns the fetch PC and selects the next PC from the F-stage prediction. It
// carries the prediction metadata through the D and E registers. In E it
// compares the prediction with the resolved outcome, and on a mispredict it
// flushes D and E and redirects fetch one cycle later. It also drives the
// predictor's resolution port and keeps branch and mispredict counters.
// Ports:
//  clk, reset                 : clock and synchronous active-high reset
//  pcF                        : current fetch PC
//  branch_predictF            : predictor says taken for pcF
//  branch_targetF             : predictor's next PC for pcF
//  instrF                     : imem data for pcF
//  stallF, stallD, bubbleE    : hazard-unit controls
//  instrD, pcD, pcE           : decode instruction/PC and execute PC
//  branchE, takenE, targetE_in: resolved branch information for the instruction in E
//  branch_valid               : predictor update strobe (valid instruction in E that is a branch)
//  branch_taken, targetE      : passthrough of the resolved outcome to the predictor
//  mispredictE, flushD, flushE: E-stage mispredict and the flushes it causes
//  perf_branches              : free-running count of resolved branches
//  perf_mispredicts           : free-running count of mispredicts
// Resolution port: the predictor samples branch_taken and targetE on any
// posedge where branch_valid is 1. There is no back-pressure.
module fetch_redirect_unit
  import fetch_pkg::*;
#(
  parameter int                      ADDRESS_WIDTH = FETCH_AW,
  parameter int                      DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] pcF,
  input  logic                     branch_predictF,
  input  logic [ADDRESS_WIDTH-1:0] branch_targetF,
  input  logic [DATA_WIDTH-1:0]    instrF,
  input  logic                     stallF,
  input  logic                     stallD,
  input  logic                     bubbleE,
  output logic [DATA_WIDTH-1:0]    instrD,
  output logic [ADDRESS_WIDTH-1:0] pcD,
  output logic [ADDRESS_WIDTH-1:0] pcE,
  input  logic                     branchE,
  input  logic                     takenE,
  input  logic [ADDRESS_WIDTH-1:0] targetE_in,
  output logic                     branch_valid,
  output logic                     branch_taken,
  output logic [ADDRESS_WIDTH-1:0] targetE,
  output logic                     mispredictE,
  output logic                     flushD,
  output logic                     flushE,
  output logic [31:0]              perf_branches,
  output logic [31:0]              perf_mispredicts
);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] correct_pc;
  logic                     flush_e_reg;
  logic [DATA_WIDTH-1:0]    instr_e_unused;
  pred_meta_t               meta_f;
  pred_meta_t               meta_d;
  pred_meta_t               meta_e;

  assign pcF = pc_q;

  // Metadata for the instruction being fetched this cycle.
  always_comb begin
    meta_f         = '0;
    meta_f.valid   = 1'b1;
    meta_f.pred    = branch_predictF;
    meta_f.predtgt = branch_targetF;
    meta_f.pc      = pc_q;
  end

  // D register: a mispredict flush beats a stall.
  fetch_pipe_reg #(.DW(DATA_WIDTH)) u_stage_d (
    .clk      (clk),
    .reset    (reset),
    .flush    (mispredictE),
    .hold     (stallD),
    .instr_in (instrF),
    .meta_in  (meta_f),
    .instr_q  (instrD),
    .meta_q   (meta_d)
  );

  // E register: a bubble or a mispredict loads the empty image. E is never held.
  // When bubbleE and stallD are both set, E takes the bubble while D holds.
  // The instruction word is not needed past D.
  assign flush_e_reg = mispredictE | bubbleE;

  fetch_pipe_reg #(.DW(DATA_WIDTH)) u_stage_e (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_e_reg),
    .hold     (1'b0),
    .instr_in (instrD),
    .meta_in  (meta_d),
    .instr_q  (instr_e_unused),
    .meta_q   (meta_e)
  );

  assign pcD = meta_d.pc;
  assign pcE = meta_e.pc;

  // Resolution port toward the predictor.
  assign branch_valid = meta_e.valid & branchE;
  assign branch_taken = takenE;
  assign targetE      = targetE_in;

  // A non-branch that the predictor called taken is an alias hit and must be
  // undone. A taken branch whose direction was right can still have gone to
  // the wrong target.
  always_comb begin
    mispredictE = 1'b0;
    if (meta_e.valid) begin
      if (branchE) begin
        mispredictE = (takenE != meta_e.pred) |
                      (takenE & meta_e.pred & (targetE_in != meta_e.predtgt));
      end else begin
        mispredictE = meta_e.pred;
      end
    end
  end

  assign flushD = mispredictE;
  assign flushE = mispredictE;

  // The fall-through add wraps modulo 2^ADDRESS_WIDTH.
  assign correct_pc = (branchE & takenE) ? targetE_in
                                         : meta_e.pc + ADDRESS_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (mispredictE) begin
      pc_q <= correct_pc;
    end else if (!stallF) begin
      pc_q <= branch_targetF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_branches    <= perf_branches + 32'(branch_valid);
      perf_mispredicts <= perf_mispredicts + 32'(mispredictE);
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Testbench for fetch_redirect_unit.
// The reference model tracks the fetch PC and the two in-flight instruction
// slots (D and E) as plain records. The driver computes the expected outputs
// for every cycle and pushes them into exp_q. The monitor pops and compares
// them on the falling edge. Directed scenarios are followed by a random phase.
module tb_fetch_redirect_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] pcF;
  logic        branch_predictF;
  logic [31:0] branch_targetF;
  logic [31:0] instrF;
  logic        stallF, stallD, bubbleE;
  logic [31:0] instrD, pcD, pcE;
  logic        branchE, takenE;
  logic [31:0] targetE_in;
  logic        branch_valid, branch_taken;
  logic [31:0] targetE;
  logic        mispredictE, flushD, flushE;
  logic [31:0] perf_branches, perf_mispredicts;

  fetch_redirect_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pcF              (pcF),
    .branch_predictF  (branch_predictF),
    .branch_targetF   (branch_targetF),
    .instrF           (instrF),
    .stallF           (stallF),
    .stallD           (stallD),
    .bubbleE          (bubbleE),
    .instrD           (instrD),
    .pcD              (pcD),
    .pcE              (pcE),
    .branchE          (branchE),
    .takenE           (takenE),
    .targetE_in       (targetE_in),
    .branch_valid     (branch_valid),
    .branch_taken     (branch_taken),
    .targetE          (targetE),
    .mispredictE      (mispredictE),
    .flushD           (flushD),
    .flushE           (flushE),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic        v;
    logic        p;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic        d_valid;
    logic [31:0] pc_d;
    logic [31:0] pc_e;
    logic        bv;
    logic        bt;
    logic [31:0] te;
    logic        mp;
    logic [31:0] pb;
    logic [31:0] pm;
  } exp_t;

  exp_t  exp_q[$];
  slot_t m_d, m_e, empty_slot;
  logic [31:0] m_pc_f, m_pb, m_pm;
  bit    m_known = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic sf, input logic sd, input logic be,
                       input logic bp, input logic [31:0] btgt, input logic [31:0] ins,
                       input logic br, input logic tk, input logic [31:0] tgt);
    logic        act_dir, mp, bv;
    logic [31:0] corr, old_pc;
    slot_t       old_d;
    exp_t        e;
    reset = rst; stallF = sf; stallD = sd; bubbleE = be;
    branch_predictF = bp; branch_targetF = btgt; instrF = ins;
    branchE = br; takenE = tk; targetE_in = tgt;

    // The actual direction is "taken" only for a taken branch. A mispredict is
    // any disagreement in direction, or a taken outcome whose target differs
    // from the predicted one.
    act_dir = br & tk;
    mp   = m_e.v && ((m_e.p != act_dir) || (act_dir && (tgt != m_e.tgt)));
    bv   = m_e.v && br;
    corr = act_dir ? tgt : m_e.pc + 32'd4;

    if (m_known) begin
      e.pc_f = m_pc_f; e.instr_d = m_d.instr; e.d_valid = m_d.v; e.pc_d = m_d.pc;
      e.pc_e = m_e.pc; e.bv = bv; e.bt = tk; e.te = tgt; e.mp = mp;
      e.pb = m_pb; e.pm = m_pm;
      exp_q.push_back(e);
    end

    if (rst) begin
      m_pc_f = 32'h0; m_d = empty_slot; m_e = empty_slot;
      m_pb = 0; m_pm = 0; m_known = 1;
    end else if (m_known) begin
      old_d  = m_d;
      old_pc = m_pc_f;
      if (mp) begin
        m_pc_f = corr; m_d = empty_slot; m_e = empty_slot;
      end else begin
        if (!sf) m_pc_f = btgt;
        if (!sd) m_d = '{1'b1, bp, btgt, old_pc, ins};
        m_e = be ? empty_slot : old_d;
      end
      m_pb = m_pb + 32'(bv);
      m_pm = m_pm + 32'(mp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic bp, input logic [31:0] btgt,
                       input logic br, input logic tk, input logic [31:0] tgt);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, bp, btgt, $urandom, br, tk, tgt);
  endtask

  task automatic seq();
    fetch(1'b0, m_pc_f + 32'd4, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  bit done = 0;
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pcF", pcF, e.pc_f);
        chk("instrD", instrD, e.instr_d);
        if (e.d_valid) chk("pcD", pcD, e.pc_d);
        chk("pcE", pcE, e.pc_e);
        chk("branch_valid", 32'(branch_valid), 32'(e.bv));
        chk("branch_taken", 32'(branch_taken), 32'(e.bt));
        chk("targetE", targetE, e.te);
        chk("mispredictE", 32'(mispredictE), 32'(e.mp));
        chk("flushD", 32'(flushD), 32'(e.mp));
        chk("flushE", 32'(flushE), 32'(e.mp));
        chk("perf_branches", perf_branches, e.pb);
        chk("perf_mispredicts", perf_mispredicts, e.pm);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        bp, br, tk;
    logic [31:0] btgt, tgt;
    empty_slot = '{1'b0, 1'b0, 32'h0, 32'h0, NOP_INSTR};
    m_d = empty_slot; m_e = empty_slot;
    m_pc_f = 0; m_pb = 0; m_pm = 0;

    // Reset for two cycles.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("reset_pcF", pcF, 32'h0);
    chk("reset_instrD", instrD, 32'h13);
    chk("reset_perf_b", perf_branches, 32'h0);

    // Sequential fetch 0,4,8,C.
    repeat (4) seq();

    // Predicted-taken branch at 0x10 to 0x40, resolved correctly.
    fetch(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    seq();
    fetch(1'b0, 32'h48, 1'b1, 1'b1, 32'h40);
    chk("t3_perf_b", perf_branches, 32'd1);
    chk("t3_perf_m", perf_mispredicts, 32'd0);

    // Direction mispredict: 0x20 predicted not-taken, resolves taken to 0x80.
    fetch(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
    fetch(1'b0, 32'h24, 1'b0, 1'b0, 32'h0);
    fetch(1'b0, 32'h28, 1'b1, 1'b1, 32'h20);
    fetch(1'b0, 32'h2C, 1'b1, 1'b1, 32'h80);
    chk("t4_pcF", pcF, 32'h80);
    chk("t4_perf_m", perf_mispredicts, 32'd1);
    chk("t4_instrD", instrD, 32'h13);

    // Alias: a non-branch at 0x30 predicted taken must redirect to 0x34.
    fetch(1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    fetch(1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
    fetch(1'b0, 32'h94, 1'b1, 1'b1, 32'h30);
    fetch(1'b0, 32'h98, 1'b0, 1'b0, 32'h0);
    chk("t5_alias_pcF", pcF, 32'h34);

    // Target mispredict: predicted 0x100, actual 0x200.
    fetch(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    seq();
    fetch(1'b0, 32'h108, 1'b1, 1'b1, 32'h200);
    chk("t5_target_pcF", pcF, 32'h200);

    // Stalls together with a mispredict: the redirect wins and D is flushed.
    fetch(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    seq();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h308, $urandom, 1'b1, 1'b0, 32'h0);
    chk("t6_stall_pcF", pcF, 32'h204);
    chk("t6_stall_instrD", instrD, 32'h13);

    // Reset asserted while a mispredict is being raised.
    fetch(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    seq();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h404, $urandom, 1'b1, 1'b0, 32'h0);
    chk("t6_reset_pcF", pcF, 32'h0);
    chk("t6_reset_perf_b", perf_branches, 32'h0);

    // Fall-through of a branch at 0xFFFFFFFC wraps to 0.
    fetch(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    fetch(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    fetch(1'b0, 32'h504, 1'b1, 1'b1, 32'hFFFF_FFFC);
    fetch(1'b0, 32'h508, 1'b1, 1'b0, 32'h0);
    chk("t6_wrap_pcF", pcF, 32'h0);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      bp   = 1'($urandom_range(0, 1));
      btgt = bp ? (32'($urandom_range(0, 63)) << 2) : m_pc_f + 32'd4;
      br   = 1'($urandom_range(0, 1));
      if (m_e.v && ($urandom_range(0, 1) == 1)) begin
        tk  = m_e.p;
        tgt = m_e.tgt;
      end else begin
        tk  = 1'($urandom_range(0, 1));
        tgt = 32'($urandom_range(0, 63)) << 2;
      end
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0),
            bp, btgt, $urandom, br, tk, tgt);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
